// File: rtl/vram_text_writer_if.sv
// ---------------------------------------------------------------------------
// vram_text_writer_if
// Bundles the two buses of the text writer:
//   character stream : in_valid, in_char[7:0] (to writer), in_ready (from writer)
//   VRAM write port  : wr_en, wr_addr[ADDR_W-1:0], wr_data[7:0] (from writer)
// Modports:
//   master : the byte source / VRAM side (drives the stream, observes writes)
//   slave  : the writer itself
// ---------------------------------------------------------------------------
interface vram_text_writer_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic [7:0]        in_char;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output in_valid, in_char,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vram_text_writer.sv
// ---------------------------------------------------------------------------
// vram_text_writer
// Character-stream front end of the text-mode display. Accepts ASCII bytes,
// keeps a cursor, writes glyph codes into character VRAM and exports the
// scroll offset (top_row) plus cursor to the scan-out adapter. Scrolling is
// done with a circular row buffer: top_row advances and a single physical
// row is blanked, nothing is copied.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous, active-low reset
//   bus        : vram_text_writer_if.slave (byte stream in, VRAM writes out)
//   top_row    : physical VRAM row displayed at screen row 0
//   cursor_col : logical cursor column, 0..FIELD_WIDTH-1
//   cursor_row : logical cursor row,    0..FIELD_HEIGHT-1
//
// Optional feature: define VRAM_TEXT_WRITER_TAB_EN to handle 0x09 as a tab
// to the next multiple-of-8 column; without it 0x09 is ignored.
// ---------------------------------------------------------------------------
module vram_text_writer #(
  parameter int FIELD_WIDTH  = 70,
  parameter int FIELD_HEIGHT = 30,
  parameter int ADDR_W       = 12
) (
  input  logic                clk,
  input  logic                rst,
  vram_text_writer_if.slave   bus,
  output logic [4:0]          top_row,
  output logic [6:0]          cursor_col,
  output logic [4:0]          cursor_row
);

  localparam int              CELLS        = FIELD_WIDTH * FIELD_HEIGHT;
  localparam logic [ADDR_W:0] CNT_INIT_END = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W:0] CNT_CLR_END  = (ADDR_W+1)'(FIELD_WIDTH);
  localparam logic [6:0]      COL_LAST     = 7'(FIELD_WIDTH - 1);
  localparam logic [4:0]      ROW_LAST     = 5'(FIELD_HEIGHT - 1);
  localparam logic [7:0]      SPACE        = 8'h20;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n;            // cell index in INIT, column in CLEAR
  logic [ADDR_W-1:0] clr_base, clr_base_n;  // first cell of the row being blanked
  logic [4:0]        top_n, row_n;
  logic [6:0]        col_n;
  logic              wr_vld_p1, wr_vld_n;
  logic [ADDR_W-1:0] wr_addr_p1, wr_addr_n;
  logic [7:0]        wr_data_p1, wr_data_n;
  logic              accept, adv;
`ifdef VRAM_TEXT_WRITER_TAB_EN
  logic [7:0]        tab_stop;
`endif

  // Logical (row, col) to VRAM cell, folding the circular row offset.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] top,
                                                  input logic [4:0] row,
                                                  input logic [6:0] col);
    int phys;
    phys = int'(top) + int'(row);
    if (phys >= FIELD_HEIGHT) phys = phys - FIELD_HEIGHT;
    return ADDR_W'(phys * FIELD_WIDTH + int'(col));
  endfunction

  assign bus.in_ready = (state == S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    clr_base_n = clr_base;
    top_n      = top_row;
    col_n      = cursor_col;
    row_n      = cursor_row;
    wr_vld_n   = 1'b0;
    wr_addr_n  = wr_addr_p1;
    wr_data_n  = wr_data_p1;
    adv        = 1'b0;
`ifdef VRAM_TEXT_WRITER_TAB_EN
    tab_stop   = {1'b0, cursor_col[6:3], 3'b000} + 8'd8;
`endif

    unique case (state)
      S_INIT: begin
        if (cnt == CNT_INIT_END) begin
          state_n = S_IDLE;
        end else begin
          wr_vld_n  = 1'b1;
          wr_addr_n = cnt[ADDR_W-1:0];
          wr_data_n = SPACE;
          cnt_n     = cnt + 1'b1;
        end
      end

      S_CLEAR: begin
        if (cnt == CNT_CLR_END) begin
          state_n = S_IDLE;
        end else begin
          wr_vld_n  = 1'b1;
          wr_addr_n = clr_base + cnt[ADDR_W-1:0];
          wr_data_n = SPACE;
          cnt_n     = cnt + 1'b1;
        end
      end

      S_IDLE: begin
        if (accept) begin
          if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7E) begin
            wr_vld_n  = 1'b1;
            wr_addr_n = cell_addr(top_row, cursor_row, cursor_col);
            wr_data_n = bus.in_char;
            if (cursor_col < COL_LAST) begin
              col_n = cursor_col + 7'd1;
            end else begin
              col_n = '0;
              adv   = 1'b1;
            end
          end else if (bus.in_char == 8'h0A || bus.in_char == 8'h0D) begin
            col_n = '0;
            adv   = 1'b1;
          end else if (bus.in_char == 8'h08) begin
            // Backspace moves first, then blanks the cell it lands on.
            if (cursor_col != '0) begin
              col_n     = cursor_col - 7'd1;
              wr_vld_n  = 1'b1;
              wr_addr_n = cell_addr(top_row, cursor_row, cursor_col - 7'd1);
              wr_data_n = SPACE;
            end else if (cursor_row != '0) begin
              row_n     = cursor_row - 5'd1;
              col_n     = COL_LAST;
              wr_vld_n  = 1'b1;
              wr_addr_n = cell_addr(top_row, cursor_row - 5'd1, COL_LAST);
              wr_data_n = SPACE;
            end
          end
`ifdef VRAM_TEXT_WRITER_TAB_EN
          else if (bus.in_char == 8'h09) begin
            if (tab_stop >= 8'(FIELD_WIDTH)) begin
              col_n = '0;
              adv   = 1'b1;
            end else begin
              col_n = tab_stop[6:0];
            end
          end
`endif
        end

        // Row advance on the last row scrolls: the old top row becomes the
        // new bottom row and is blanked by CLEAR.
        if (adv) begin
          if (cursor_row < ROW_LAST) begin
            row_n = cursor_row + 5'd1;
          end else begin
            top_n      = (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;
            clr_base_n = cell_addr(top_row, 5'd0, 7'd0);
            cnt_n      = '0;
            state_n    = S_CLEAR;
          end
        end
      end

      default: state_n = S_INIT;
    endcase
  end

  // Stage p1: registered VRAM write, cursor and scroll state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_INIT;
      cnt        <= '0;
      clr_base   <= '0;
      top_row    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      clr_base   <= clr_base_n;
      top_row    <= top_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
      wr_vld_p1  <= wr_vld_n;
      wr_addr_p1 <= wr_addr_n;
      wr_data_p1 <= wr_data_n;
    end
  end

  assign bus.wr_en   = wr_vld_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.wr_data = wr_data_p1;

endmodule

// File: tb/tb_vram_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_text_writer
// Self-checking bench for vram_text_writer (70x30 field, 12-bit addresses).
// Expected VRAM writes are queued when a byte is driven and matched in order
// by a monitor on the falling clock edge. Single-byte behaviour is a table of
// vectors; INIT, scrolling, reset during CLEAR and tab are hand sequences.
// ---------------------------------------------------------------------------
module tb_vram_text_writer;

  localparam int FW = 70;
  localparam int FH = 30;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    bit         has_wr;
    int         addr;
    logic [7:0] data;
    int         col;
    int         row;
  } vec_t;

  logic clk;
  logic rst;
  logic [4:0] top_row;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int  checks;
  int  errors;
  int  wr_seen;
  wr_t exp_q[$];

  vram_text_writer_if #(.ADDR_W(12)) bus ();

  vram_text_writer #(
    .FIELD_WIDTH (FW),
    .FIELD_HEIGHT(FH),
    .ADDR_W      (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .top_row   (top_row),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = 12'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Write monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
  end

  // Drive one byte; waits (bounded) for in_ready, returns in the cycle after accept.
  task automatic send(input logic [7:0] ch);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got %b after %0d cycles, expected 1", bus.in_ready, w);
    end
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int col, input int row, input int top);
    check({tag, "_col"}, 32'(cursor_col), 32'(col));
    check({tag, "_row"}, 32'(cursor_row), 32'(row));
    check({tag, "_top"}, 32'(top_row), 32'(top));
  endtask

  task automatic check_drained(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    check_cursor(tag, 0, 0, 0);
  endtask

  // Called with rst low, just after a clock edge; releases reset and follows INIT.
  task automatic run_init(input string tag);
    int cyc;
    cyc = 0;
    for (int a = 0; a < FW * FH; a++) push_wr(a, 8'h20);
    wr_seen = 0;
    rst = 1'b1;
    while (bus.in_ready !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_ready_cycle"}, 32'(cyc), 32'd2101);
    check({tag, "_write_count"}, 32'(wr_seen), 32'd2100);
    check({tag, "_pending"},     32'(exp_q.size()), 32'd0);
    check_cursor(tag, 0, 0, 0);
  endtask

  // Waits for in_ready to return after a scroll; returns cycles spent.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  vec_t vecs[19];

  initial begin
    int cyc;

    // Single-byte vectors, starting from cursor (0,1), top_row 0.
    vecs[0]  = '{8'h07, 1'b0, 0,   8'h00, 0, 1};
    vecs[1]  = '{8'h7F, 1'b0, 0,   8'h00, 0, 1};
    vecs[2]  = '{8'h7E, 1'b1, 70,  8'h7E, 1, 1};
    vecs[3]  = '{8'h0D, 1'b0, 0,   8'h00, 0, 2};
    vecs[4]  = '{8'h20, 1'b1, 140, 8'h20, 1, 2};
    vecs[5]  = '{8'h0A, 1'b0, 0,   8'h00, 0, 3};
    vecs[6]  = '{8'h68, 1'b1, 210, 8'h68, 1, 3};
    vecs[7]  = '{8'h65, 1'b1, 211, 8'h65, 2, 3};
    vecs[8]  = '{8'h6C, 1'b1, 212, 8'h6C, 3, 3};
    vecs[9]  = '{8'h6C, 1'b1, 213, 8'h6C, 4, 3};
    vecs[10] = '{8'h6F, 1'b1, 214, 8'h6F, 5, 3};
    vecs[11] = '{8'h08, 1'b1, 214, 8'h20, 4, 3};
    vecs[12] = '{8'h08, 1'b1, 213, 8'h20, 3, 3};
    vecs[13] = '{8'h0A, 1'b0, 0,   8'h00, 0, 4};
    vecs[14] = '{8'h08, 1'b1, 279, 8'h20, 69, 3};
    vecs[15] = '{8'h5A, 1'b1, 279, 8'h5A, 0, 4};
    vecs[16] = '{8'h71, 1'b1, 280, 8'h71, 1, 4};
    vecs[17] = '{8'h00, 1'b0, 0,   8'h00, 1, 4};
    vecs[18] = '{8'h1F, 1'b0, 0,   8'h00, 1, 4};

    checks       = 0;
    errors       = 0;
    wr_seen      = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    // Reset for two cycles, then INIT sweep.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    run_init("init");

    // Backspace at origin, first glyph, backspace over it.
    send(8'h08);
    check_cursor("bs_origin", 0, 0, 0);
    check_drained("bs_origin");
    push_wr(0, 8'h41);
    send(8'h41);
    check("first_wr_en", 32'(bus.wr_en), 32'd1);
    check_cursor("first_A", 1, 0, 0);
    check_drained("first_A");
    push_wr(0, 8'h20);
    send(8'h08);
    check_cursor("bs_A", 0, 0, 0);
    check_drained("bs_A");

    // A full row of printables wraps to the next row without clearing.
    for (int i = 0; i < FW; i++) begin
      push_wr(i, 8'h30 + 8'(i % 10));
      send(8'h30 + 8'(i % 10));
    end
    check_cursor("row_fill", 0, 1, 0);
    check("row_fill_ready", 32'(bus.in_ready), 32'd1);
    check_drained("row_fill");

    // Table-driven single bytes.
    for (int v = 0; v < 19; v++) begin
      if (vecs[v].has_wr) push_wr(vecs[v].addr, vecs[v].data);
      send(vecs[v].ch);
      check_cursor($sformatf("vec%0d", v), vecs[v].col, vecs[v].row, 0);
      check_drained($sformatf("vec%0d", v));
    end

    // Move to the last row.
    for (int i = 0; i < 25; i++) send(8'h0A);
    check_cursor("to_bottom", 0, 29, 0);
    check("to_bottom_ready", 32'(bus.in_ready), 32'd1);

    // Newline on the last row: scroll, blank physical row 0.
    for (int c = 0; c < FW; c++) push_wr(c, 8'h20);
    send(8'h0A);
    check("scroll_nl_ready_low", 32'(bus.in_ready), 32'd0);
    check_cursor("scroll_nl", 0, 29, 1);
    wait_ready(cyc);
    check("scroll_nl_busy_cycles", 32'(cyc), 32'd71);
    check("scroll_nl_pending", 32'(exp_q.size()), 32'd0);

    // Fill the bottom row (physical row 0); last glyph writes, then scrolls.
    for (int i = 0; i < FW - 1; i++) begin
      push_wr(i, 8'h62);
      send(8'h62);
    end
    check_cursor("bottom_fill", 69, 29, 1);
    push_wr(69, 8'h63);
    for (int c = 0; c < FW; c++) push_wr(70 + c, 8'h20);
    send(8'h63);
    check("glyph_scroll_ready_low", 32'(bus.in_ready), 32'd0);
    check_cursor("glyph_scroll", 0, 29, 2);
    wait_ready(cyc);
    check("glyph_scroll_busy_cycles", 32'(cyc), 32'd71);
    check("glyph_scroll_pending", 32'(exp_q.size()), 32'd0);

    // Scroll through the remaining rows so top_row wraps back to 0.
    for (int t = 2; t < FH; t++) begin
      for (int c = 0; c < FW; c++) push_wr(t * FW + c, 8'h20);
      send(8'h0A);
    end
    wait_ready(cyc);
    check_cursor("top_wrap", 0, 29, 0);
    check("top_wrap_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a CLEAR.
    for (int c = 0; c < FW; c++) push_wr(c, 8'h20);
    wr_seen = 0;
    send(8'h0A);
    check_cursor("mid_clear", 0, 29, 1);
    cyc = 0;
    while (wr_seen < 30 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("mid_clear_writes", 32'(wr_seen), 32'd30);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("mid_reset");
    exp_q.delete();
    run_init("reinit");

    // Tab handling.
    send(8'h09);
`ifdef VRAM_TEXT_WRITER_TAB_EN
    check_cursor("tab0", 8, 0, 0);
`else
    check_cursor("tab0", 0, 0, 0);
`endif
    check_drained("tab0");
    send(8'h0A);
    for (int i = 0; i < 66; i++) begin
      push_wr(70 + i, 8'h61);
      send(8'h61);
    end
    check_cursor("tab_pre", 66, 1, 0);
    send(8'h09);
`ifdef VRAM_TEXT_WRITER_TAB_EN
    check_cursor("tab66", 0, 2, 0);
`else
    check_cursor("tab66", 66, 1, 0);
`endif
    check_drained("tab66");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_text_writer.md
# vram_text_writer

Character-stream front end of the text-mode display path. It accepts ASCII bytes over a valid/ready handshake and maintains a cursor. It writes glyph codes into the character VRAM that the character visual adapter reads during scan-out, and exports the scroll offset and cursor position to that adapter. Scrolling uses a circular row buffer: scroll bumps `top_row` and clears one row instead of copying VRAM.

## Interface
- `FIELD_WIDTH`, 70, columns per text row.
- `FIELD_HEIGHT`, 30, text rows on screen.
- `ADDR_W`, 12, VRAM address width; must satisfy 2^ADDR_W ≥ FIELD_WIDTH*FIELD_HEIGHT.
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `in_valid` in 1: `in_char` holds a byte.
- `in_char` in 8: ASCII byte.
- `in_ready` out 1: block can accept a byte this cycle.
- `wr_en` out 1: VRAM write strobe, one cycle per cell.
- `wr_addr` out ADDR_W: VRAM cell address, phys_row*FIELD_WIDTH+col.
- `wr_data` out 8: byte written to VRAM.
- `top_row` out 5: physical VRAM row shown at screen row 0.
- `cursor_col` out 7: logical cursor column, 0..FIELD_WIDTH-1.
- `cursor_row` out 5: logical cursor row, 0..FIELD_HEIGHT-1.

## Operation
- Address mapping: phys_row = (top_row + logical_row) mod FIELD_HEIGHT.
- States:
  - INIT: writes 0x20 to cells 0..FIELD_WIDTH*FIELD_HEIGHT-1 in ascending order, one per cycle, then goes to IDLE.
  - IDLE: `in_ready`=1.
  - CLEAR: writes 0x20 to all columns of one physical row, col 0 ascending, one per cycle, then goes to IDLE.
- A byte is accepted when `in_valid && in_ready`. Each accepted byte is handled exactly once; `in_ready` drops in INIT and CLEAR.
- Printable byte (0x20..0x7E):
  - Write the byte at the cursor.
  - If col < FIELD_WIDTH-1: col+1.
  - Otherwise: col=0 and advance the row.
- 0x0A or 0x0D: no write; col=0; advance the row.
- 0x08 (backspace):
  - col>0: col-1, then write 0x20 at the new position.
  - col=0 and row>0: row-1, col=FIELD_WIDTH-1, write 0x20 there.
  - (0,0): no write, no move. Backspace never scrolls back.
- Any other byte is dropped with no effect.
- Row advance:
  - row < FIELD_HEIGHT-1: row+1.
  - row = FIELD_HEIGHT-1: row stays; top_row = (top_row+1) mod FIELD_HEIGHT; enter CLEAR on the physical row equal to the old top_row (the new bottom row).
- Printable byte at the last cell of the last row: the glyph write happens first, then the scroll.

## Timing
- Reset values:
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `top_row`=0, `cursor_col`=0, `cursor_row`=0.
  - State = INIT.
- INIT asserts `wr_en` on the first cycle after `rst` deasserts. It runs exactly FIELD_WIDTH*FIELD_HEIGHT cycles (2100 by default). `in_ready` rises the cycle after the last write.
- Accept-to-write latency is 1 cycle: `wr_*` are registered. The write appears on the cycle after the accept edge.
- Cursor and top_row update on the same edge that registers the write.
- `in_ready` falls on the edge where a scrolling byte is accepted. CLEAR runs exactly FIELD_WIDTH write cycles:
  - the glyph write (if any) comes first;
  - then FIELD_WIDTH clear writes;
  - `in_ready` returns the cycle after the last clear write.
- `rst` low mid-INIT or mid-CLEAR:
  - the next edge restores all reset values and restarts INIT from cell 0;
  - no partial state survives.
- top_row wraps FIELD_HEIGHT-1 → 0.
- `wr_addr` is always < FIELD_WIDTH*FIELD_HEIGHT.

## Configuration
- `VRAM_TEXT_WRITER_TAB_EN` defined:
  - 0x09 moves col to the next multiple of 8, with no VRAM write.
  - If that value is ≥ FIELD_WIDTH: col=0 and advance the row, including scroll.
- `VRAM_TEXT_WRITER_TAB_EN` undefined: 0x09 is dropped like any other non-handled byte.

## Test plan
- Reset low 2 cycles, then high:
  - exactly 2100 `wr_en` pulses, addresses 0..2099, data 0x20;
  - `in_ready` first high at cycle 2101.
- After INIT, send 'A' (0x41): the next cycle shows `wr_en`=1, `wr_addr`=0, `wr_data`=0x41; cursor becomes (col 1, row 0).
- Send 70 printable bytes from (0,0): the last write has `wr_addr`=69, and the cursor ends at (col 0, row 1) with no CLEAR.
- Cursor at row 29, top_row 0, send 0x0A:
  - top_row becomes 1;
  - 70 writes of 0x20 to addresses 0..69;
  - `in_ready` low for the entire CLEAR, and cursor is (0,29).
- At (0,0) send 0x08: no `wr_en`. At (5,3) send 0x08: write 0x20 at address 214, cursor becomes (4,3).
- Assert `rst` low at clear cycle 30 of a scroll: top_row, cursor and state return to reset values, and INIT restarts at address 0.
- With the macro defined, 0x09 at col 66 moves the cursor to (0,row+1). With the macro undefined, 0x09 leaves the cursor unchanged.
